// File: rtl/tug_of_war_referee_if.sv
// Key, light and score signals between the tug-of-war referee and its surroundings.
// The referee takes the slave side; the key/playfield side takes the master side.
interface tug_of_war_referee_if #(
  parameter int N_LIGHTS = 9,
  parameter int SCORE_W  = 3
);
  logic                keyL;
  logic                keyR;
  logic                restart;
  logic [N_LIGHTS-1:0] lights;
  logic                L;
  logic                R;
  logic                fieldReset;
  logic [SCORE_W-1:0]  leftScore;
  logic [SCORE_W-1:0]  rightScore;
  logic [1:0]          winner;
  logic                gameOver;

  modport master (
    output keyL, keyR, restart, lights,
    input  L, R, fieldReset, leftScore, rightScore, winner, gameOver
  );

  modport slave (
    input  keyL, keyR, restart, lights,
    output L, R, fieldReset, leftScore, rightScore, winner, gameOver
  );
endinterface

// File: rtl/tug_of_war_referee.sv
// Tug-of-war match controller: conditions the keys into move pulses, scores points,
// clears the playfield between points and declares the match winner.
module tug_of_war_referee #(
  parameter int N_LIGHTS   = 9,
  parameter int WIN_SCORE  = 7,
  parameter int SCORE_W    = 3,
  parameter int CLR_CYCLES = 4
) (
  input logic                  Clock,
  input logic                  Reset,
  tug_of_war_referee_if.slave  bus
);
  localparam int                 CNT_W    = $clog2(CLR_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {CLEAR, PLAY, OVER} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               syncL_p0, syncL_p1, syncL_p2;
  logic               syncR_p0, syncR_p1, syncR_p2;
  logic               riseL, riseR;
  logic               L_q, R_q;
  logic               leftPt, rightPt;
  logic [SCORE_W-1:0] leftScore_q, rightScore_q;
  logic [1:0]         winner_q;
  logic               unused_lights;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN_S) ? WIN_S : s + 1'b1;
  endfunction

  assign riseL   = syncL_p1 & ~syncL_p2;
  assign riseR   = syncR_p1 & ~syncR_p2;
  // Points are judged on the pulse cycle against the lights before the move lands.
  assign leftPt  = L_q & ~R_q & bus.lights[N_LIGHTS-1];
  assign rightPt = R_q & ~L_q & bus.lights[0];

  assign unused_lights = ^bus.lights[N_LIGHTS-2:1];

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= CLEAR;
      cnt          <= '0;
      syncL_p0     <= 1'b0;
      syncL_p1     <= 1'b0;
      syncL_p2     <= 1'b0;
      syncR_p0     <= 1'b0;
      syncR_p1     <= 1'b0;
      syncR_p2     <= 1'b0;
      L_q          <= 1'b0;
      R_q          <= 1'b0;
      leftScore_q  <= '0;
      rightScore_q <= '0;
      winner_q     <= 2'b00;
    end else begin
      // stage p0/p1: synchroniser, p2: history for edge detection
      syncL_p0 <= bus.keyL;
      syncL_p1 <= syncL_p0;
      syncL_p2 <= syncL_p1;
      syncR_p0 <= bus.keyR;
      syncR_p1 <= syncR_p0;
      syncR_p2 <= syncR_p1;
      L_q      <= 1'b0;
      R_q      <= 1'b0;
      case (state)
        CLEAR: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= PLAY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PLAY: begin
          if (leftPt) begin
            leftScore_q <= sat_inc(leftScore_q);
            cnt         <= '0;
            if (sat_inc(leftScore_q) == WIN_S) begin
              state    <= OVER;
              winner_q <= 2'b10;
            end else begin
              state <= CLEAR;
            end
          end else if (rightPt) begin
            rightScore_q <= sat_inc(rightScore_q);
            cnt          <= '0;
            if (sat_inc(rightScore_q) == WIN_S) begin
              state    <= OVER;
              winner_q <= 2'b01;
            end else begin
              state <= CLEAR;
            end
          end else begin
            // Pulses only leave while the field stays in play.
            L_q <= riseL;
            R_q <= riseR;
          end
        end
        OVER: begin
          if (bus.restart) begin
            leftScore_q  <= '0;
            rightScore_q <= '0;
            winner_q     <= 2'b00;
            cnt          <= '0;
            state        <= CLEAR;
          end
        end
        default: begin
          cnt   <= '0;
          state <= CLEAR;
        end
      endcase
    end
  end

  assign bus.L          = L_q;
  assign bus.R          = R_q;
  assign bus.fieldReset = ~Reset | (state == CLEAR) | (state == OVER);
  assign bus.leftScore  = leftScore_q;
  assign bus.rightScore = rightScore_q;
  assign bus.winner     = winner_q;
  assign bus.gameOver   = (state == OVER);
endmodule
